// File: rtl/crc_pkg.sv
// Shared constants, FSM state type and the single-bit CRC-32 update used by the
// frame checker.
package crc_pkg;

  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_XOROUT    = 32'hFFFFFFFF;
  localparam int unsigned CRC_BYTES     = 4;

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StWaitPay,
    StTrailer,
    StDone
  } state_e;

  // One LSB-first step of the reflected CRC-32.
  function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic din);
    logic fb;
    fb = crc[0] ^ din;
    return (crc >> 1) ^ (fb ? CRC_POLY_REFL : 32'h0000_0000);
  endfunction

endpackage

// File: rtl/crc32_serial_engine.sv
// Bit-serial CRC-32 register: load to the init value, or advance one data bit
// per enabled cycle.
module crc32_serial_engine
  import crc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_init,
  input  logic        step_en,
  input  logic        data_bit,
  output logic [31:0] crc
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (load_init) begin
      crc_d = CRC_INIT;
    end else if (step_en) begin
      crc_d = crc32_step(crc_q, data_bit);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/crc32_frame_checker.sv
// Frame-level CRC-32 checker: accepts PAYLOAD_LEN bytes (shifted bit-serially),
// captures a little-endian 4-byte trailer and reports the computed CRC and match flag.
module crc32_frame_checker
  import crc_pkg::*;
#(
  parameter int unsigned PAYLOAD_LEN    = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] crc_value,
  output logic        crc_ok,
  output logic        frame_done,
  output logic        frame_abort,
  output logic        busy
);

  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);

  state_e state_q, state_d;

  logic [7:0]     byte_q;
  logic [7:0]     byte_cnt_q;
  logic [2:0]     bit_cnt_q;
  logic [1:0]     trl_cnt_q;
  logic [31:0]    rx_crc_q;
  logic [ToW-1:0] to_cnt_q;
  logic [31:0]    crc_value_q;
  logic           crc_ok_q;
  logic           frame_done_q;
  logic           frame_abort_q;

  logic [31:0] crc_reg;
  logic [31:0] crc_final;
  logic [31:0] rx_crc_full;
  logic        accept;
  logic        last_bit;
  logic        last_byte;
  logic        last_trl;
  logic        waiting;
  logic        timeout;
  logic        trl_done;

  assign accept    = rx_valid && rx_ready;
  assign last_bit  = (bit_cnt_q == 3'd7);
  assign last_byte = (byte_cnt_q == 8'(PAYLOAD_LEN));
  assign last_trl  = (trl_cnt_q == 2'(CRC_BYTES - 1));
  assign waiting   = (state_q == StWaitPay) || (state_q == StTrailer);
  // A byte arriving on the expiry cycle wins over the abort.
  assign timeout   = waiting && !accept && (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1));
  assign trl_done  = (state_q == StTrailer) && accept && last_trl;

  // Final trailer byte lands in [31:24] on the same edge the result is registered.
  assign crc_final   = crc_reg ^ CRC_XOROUT;
  assign rx_crc_full = {rx_data, rx_crc_q[23:0]};

  crc32_serial_engine u_engine (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_init ((state_q == StIdle) && accept),
    .step_en   (state_q == StShift),
    .data_bit  (byte_q[bit_cnt_q]),
    .crc       (crc_reg)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StShift;
      end
      StShift: begin
        if (last_bit) state_d = last_byte ? StTrailer : StWaitPay;
      end
      StWaitPay: begin
        if (accept) begin
          state_d = StShift;
        end else if (timeout) begin
          state_d = StIdle;
        end
      end
      StTrailer: begin
        if (trl_done) begin
          state_d = StDone;
        end else if (timeout) begin
          state_d = StIdle;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    rx_ready = 1'b0;
    busy     = 1'b1;
    unique case (state_q)
      StIdle: begin
        rx_ready = 1'b1;
        busy     = 1'b0;
      end
      StWaitPay, StTrailer: rx_ready = 1'b1;
      default: rx_ready = 1'b0;
    endcase
  end

  // Datapath: byte latch, counters, trailer capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_q     <= 8'h00;
      byte_cnt_q <= 8'h00;
      bit_cnt_q  <= 3'd0;
      trl_cnt_q  <= 2'd0;
      rx_crc_q   <= 32'h0000_0000;
      to_cnt_q   <= '0;
    end else begin
      if (accept && (state_q != StTrailer)) begin
        byte_q <= rx_data;
      end

      if (state_q == StShift) begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end else begin
        bit_cnt_q <= 3'd0;
      end

      if ((state_q == StIdle) && accept) begin
        byte_cnt_q <= 8'd1;
      end else if ((state_q == StWaitPay) && accept) begin
        byte_cnt_q <= byte_cnt_q + 8'd1;
      end

      if ((state_q == StShift) && last_bit) begin
        trl_cnt_q <= 2'd0;
      end else if ((state_q == StTrailer) && accept) begin
        trl_cnt_q                      <= trl_cnt_q + 2'd1;
        rx_crc_q[{trl_cnt_q, 3'b000} +: 8] <= rx_data;
      end

      if (accept || timeout || (state_q == StIdle)) begin
        to_cnt_q <= '0;
      end else if (waiting) begin
        to_cnt_q <= to_cnt_q + {{(ToW - 1){1'b0}}, 1'b1};
      end
    end
  end

  // Registered results and pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_value_q   <= 32'h0000_0000;
      crc_ok_q      <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      frame_done_q  <= trl_done;
      frame_abort_q <= timeout;
      if (trl_done) begin
        crc_value_q <= crc_final;
        crc_ok_q    <= (crc_final == rx_crc_full);
      end
    end
  end

  assign crc_value   = crc_value_q;
  assign crc_ok      = crc_ok_q;
  assign frame_done  = frame_done_q;
  assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_crc32_frame_checker.sv
// Scoreboard bench for crc32_frame_checker: frames are queued with their expected
// CRC/flag when driven and checked whenever the DUT pulses frame_done.
module tb_crc32_frame_checker;

  localparam int unsigned PAY = 9;
  localparam int unsigned TO  = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] crc_value;
  logic        crc_ok;
  logic        frame_done;
  logic        frame_abort;
  logic        busy;

  typedef struct {
    logic [31:0] crc;
    logic        ok;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  pay[PAY];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_done = 0;
  int          n_abort = 0;
  int          n_frames_exp = 0;
  logic [31:0] last_exp_crc = 32'h0;
  logic        last_exp_ok = 1'b0;

  always #5 clk = ~clk;

  crc32_frame_checker #(
    .PAYLOAD_LEN    (PAY),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .crc_value   (crc_value),
    .crc_ok      (crc_ok),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .busy        (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference byte-wise reflected CRC-32 over pay[].
  function automatic logic [31:0] crc_ref();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < PAY; i++) begin
      c = c ^ {24'h0, pay[i]};
      for (int k = 0; k < 8; k++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  always @(negedge clk) begin
    if (rst_n && frame_done) begin
      n_done++;
      if (sb_q.size() == 0) begin
        check_eq("sb_has_entry", sb_q.size(), 1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("crc_value", crc_value, e.crc);
        check_eq("crc_ok", {31'h0, crc_ok}, {31'h0, e.ok});
      end
    end
    if (rst_n && frame_abort) n_abort++;
  end

  // Called at a negedge; returns at the negedge after the accepting posedge.
  // n = cycles spent waiting for rx_ready.
  task automatic send_byte(input logic [7:0] b, output int n);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check_eq("ready_wait", n, 0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    rx_valid = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] trailer, input logic [31:0] exp_crc,
                            input int stall_at, input int stall, output int first_wait);
    int n;
    exp_t e;
    e.crc = exp_crc;
    e.ok  = (trailer == exp_crc);
    sb_q.push_back(e);
    n_frames_exp++;
    last_exp_crc = exp_crc;
    last_exp_ok  = e.ok;
    first_wait = 0;
    for (int i = 0; i < PAY; i++) begin
      if (i == stall_at) begin
        rx_valid = 1'b0;
        repeat (stall) @(negedge clk);
      end
      send_byte(pay[i], n);
      if (i == 0) first_wait = n;
      else if (i != stall_at) check_eq("pay_gap", n, 8);
    end
    for (int j = 0; j < 4; j++) begin
      send_byte(trailer[8*j +: 8], n);
      if (j == 0) check_eq("trl_gap_first", n, 8);
      else check_eq("trl_gap", n, 0);
    end
    check_eq("done_latency", {31'h0, frame_done}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int    w;
    int    k;
    string s;
    logic [31:0] c;

    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
    check_eq("rst_crc_value", crc_value, 32'h0);
    check_eq("rst_crc_ok", {31'h0, crc_ok}, 32'h0);
    check_eq("rst_frame_done", {31'h0, frame_done}, 32'h0);
    check_eq("rst_frame_abort", {31'h0, frame_abort}, 32'h0);
    check_eq("rst_busy", {31'h0, busy}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Known check value, then a corrupted trailer back-to-back
    s = "123456789";
    for (int i = 0; i < PAY; i++) pay[i] = s[i];
    send_frame(32'hCBF43926, 32'hCBF43926, -1, 0, w);
    check_eq("first_wait_idle", w, 0);
    send_frame(32'hCBF43927, 32'hCBF43926, -1, 0, w);
    check_eq("b2b_gap", w, 1);
    idle(2);

    // Random payloads, some with a single flipped trailer bit
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < PAY; i++) pay[i] = 8'($urandom_range(0, 255));
      c = crc_ref();
      if (f % 2 == 1) send_frame(c ^ (32'h1 << $urandom_range(0, 31)), c, -1, 0, w);
      else send_frame(c, c, -1, 0, w);
      idle($urandom_range(0, 3));
    end

    // Timeout after 3 payload bytes
    for (int i = 0; i < PAY; i++) pay[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 3; i++) send_byte(pay[i], w);
    rx_valid = 1'b0;
    k = 1;
    while (!frame_abort && k < 100) begin
      @(negedge clk);
      k++;
    end
    // 8 shift cycles, then TO idle cycles, then the registered pulse
    check_eq("abort_latency", k, 8 + TO + 1);
    check_eq("abort_hold_crc", crc_value, last_exp_crc);
    check_eq("abort_hold_ok", {31'h0, crc_ok}, {31'h0, last_exp_ok});
    @(negedge clk);
    check_eq("abort_pulse_width", {31'h0, frame_abort}, 32'h0);
    check_eq("abort_idle", {31'h0, busy}, 32'h0);
    c = crc_ref();
    send_frame(c, c, -1, 0, w);
    idle(1);

    // Byte presented on the expiry cycle must be taken, not aborted
    for (int i = 0; i < PAY; i++) pay[i] = 8'($urandom_range(0, 255));
    c = crc_ref();
    send_frame(c, c, 3, 8 + TO - 1, w);
    idle(1);

    // Reset during SHIFT
    send_byte(8'hA5, w);
    send_byte(8'h5A, w);
    rx_valid = 1'b0;
    @(negedge clk);
    check_eq("mid_busy", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_rx_ready", {31'h0, rx_ready}, 32'h1);
    check_eq("mid_rst_busy", {31'h0, busy}, 32'h0);
    check_eq("mid_rst_crc_value", crc_value, 32'h0);
    check_eq("mid_rst_crc_ok", {31'h0, crc_ok}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < PAY; i++) pay[i] = 8'($urandom_range(0, 255));
    c = crc_ref();
    send_frame(c, c, -1, 0, w);
    check_eq("post_rst_first_wait", w, 0);
    idle(3);

    check_eq("sb_drained", sb_q.size(), 0);
    check_eq("done_count", n_done, n_frames_exp);
    check_eq("abort_count", n_abort, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
